// File: rtl/regfile_mp_if.sv
// Bundle for the register file's read, write and status signals.
// The master drives addresses, enables and write data; the slave is the register file.
interface regfile_mp_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 5
);
   logic [AW-1:0]    ra0;
   logic [WIDTH-1:0] rd0;
   logic [AW-1:0]    ra1;
   logic [WIDTH-1:0] rd1;
   logic [AW-1:0]    wa0;
   logic             we0;
   logic [WIDTH-1:0] wd0;
   logic [AW-1:0]    wa1;
   logic             we1;
   logic [WIDTH-1:0] wd1;
   logic             ready;

   modport master (
      output ra0, ra1, wa0, we0, wd0, wa1, we1, wd1,
      input  rd0, rd1, ready
   );

   modport slave (
      input  ra0, ra1, wa0, we0, wd0, wa1, we1, wd1,
      output rd0, rd1, ready
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: two async read ports with write bypass, two sync write ports
// (port 1 wins on collision), optional hardwired-zero entry 0, and a self-clearing reset sequencer.
module regfile_mp #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int ZERO_REG = 1
) (
   input logic         clk,
   input logic         rst,
   regfile_mp_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   localparam bit ZR = (ZERO_REG != 0);

   localparam logic ST_CLEAR = 1'b0;
   localparam logic ST_RUN   = 1'b1;

   logic             state_q, state_d;
   logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
   logic             ready_q, ready_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             live;
   logic             wr0_ok, wr1_ok;

   // Ports are dead during the reset cycle itself, not only from the following edge.
   assign live   = ready_q & ~rst;
   assign wr0_ok = bus.we0 & ~(ZR & (bus.wa0 == '0));
   assign wr1_ok = bus.we1 & ~(ZR & (bus.wa1 == '0));

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      ready_d   = ready_q;
      mem_d     = mem_q;
      if (state_q == ST_CLEAR) begin
         mem_d[clr_cnt_q] = '0;
         clr_cnt_d        = clr_cnt_q + 1'b1;
         if (clr_cnt_q == LAST) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
         end
      end else begin
         // Port 1 applied last so it overrides port 0 on a shared address.
         if (wr0_ok) mem_d[bus.wa0] = bus.wd0;
         if (wr1_ok) mem_d[bus.wa1] = bus.wd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         ready_q   <= ready_d;
         mem_q     <= mem_d;
      end
   end

   always_comb begin
      bus.rd0 = '0;
      if (live && !(ZR && bus.ra0 == '0)) begin
         if (wr1_ok && bus.wa1 == bus.ra0)      bus.rd0 = bus.wd1;
         else if (wr0_ok && bus.wa0 == bus.ra0) bus.rd0 = bus.wd0;
         else                                   bus.rd0 = mem_q[bus.ra0];
      end
   end

   always_comb begin
      bus.rd1 = '0;
      if (live && !(ZR && bus.ra1 == '0)) begin
         if (wr1_ok && bus.wa1 == bus.ra1)      bus.rd1 = bus.wd1;
         else if (wr0_ok && bus.wa0 == bus.ra1) bus.rd1 = bus.wd0;
         else                                   bus.rd1 = mem_q[bus.ra1];
      end
   end

   assign bus.ready = live;
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: driver predicts each cycle's outputs from an array model,
// monitor compares on the falling edge.
module tb_regfile_mp;
   localparam int WIDTH = 32;
   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   regfile_mp_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

   regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [WIDTH-1:0] rd0;
      logic [WIDTH-1:0] rd1;
      logic             rdy;
      int               id;
   } exp_t;

   exp_t sbq[$];
   int tests = 0;
   int fails = 0;
   int step_id = 0;

   // Reference model: array contents, edges spent clearing, and whether ports are live.
   logic [WIDTH-1:0] model [DEPTH];
   int clear_edges = 0;
   bit running = 1'b0;

   function automatic logic [WIDTH-1:0] model_read(input logic r, input logic [AW-1:0] a,
         input logic e0, input logic [AW-1:0] w0a, input logic [WIDTH-1:0] d0,
         input logic e1, input logic [AW-1:0] w1a, input logic [WIDTH-1:0] d1);
      if (!running || r || a == 0) return '0;
      if (e1 && w1a == a) return d1;
      if (e0 && w0a == a) return d0;
      return model[a];
   endfunction

   task automatic step(input logic r, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
         input logic e0, input logic [AW-1:0] w0a, input logic [WIDTH-1:0] d0,
         input logic e1, input logic [AW-1:0] w1a, input logic [WIDTH-1:0] d1);
      exp_t e;
      rst = r;
      bus.ra0 = a0; bus.ra1 = a1;
      bus.we0 = e0; bus.wa0 = w0a; bus.wd0 = d0;
      bus.we1 = e1; bus.wa1 = w1a; bus.wd1 = d1;
      e.rd0 = model_read(r, a0, e0, w0a, d0, e1, w1a, d1);
      e.rd1 = model_read(r, a1, e0, w0a, d0, e1, w1a, d1);
      e.rdy = running && !r;
      e.id  = step_id;
      step_id++;
      sbq.push_back(e);
      @(posedge clk);
      if (r) begin
         running = 1'b0;
         clear_edges = 0;
      end else if (!running) begin
         clear_edges++;
         if (clear_edges == DEPTH) begin
            running = 1'b1;
            foreach (model[i]) model[i] = '0;
         end
      end else begin
         if (e0 && w0a != 0) model[w0a] = d0;
         if (e1 && w1a != 0) model[w1a] = d1;
      end
      #1;
   endtask

   task automatic rnd_step(input logic r, input int amax);
      step(r, AW'($urandom_range(0, DEPTH-1)), AW'($urandom_range(0, DEPTH-1)),
           1'($urandom), AW'($urandom_range(0, amax)), $urandom,
           1'($urandom), AW'($urandom_range(0, amax)), $urandom);
   endtask

   task automatic rd_step(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      step(1'b0, a0, a1, 1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic check(input string name, input int id, input logic [WIDTH-1:0] got,
         input logic [WIDTH-1:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s step=%0d got=%h exp=%h", name, id, got, exp);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("ready", e.id, WIDTH'(bus.ready), WIDTH'(e.rdy));
            check("rd0", e.id, bus.rd0, e.rd0);
            check("rd1", e.id, bus.rd1, e.rd1);
         end
      end
   end

   initial begin : driver
      bus.ra0 = '0; bus.ra1 = '0;
      bus.we0 = 1'b0; bus.wa0 = '0; bus.wd0 = '0;
      bus.we1 = 1'b0; bus.wa1 = '0; bus.wd1 = '0;
      @(posedge clk);
      #1;

      // Reset, then full clear sequence with write attempts that must be ignored.
      rnd_step(1'b1, DEPTH-1);
      rnd_step(1'b1, DEPTH-1);
      for (int i = 0; i < DEPTH + 2; i++) begin
         if (i == 4) step(1'b0, 3, 3, 1'b1, 3, 32'h55, 1'b0, 0, 0);
         else rnd_step(1'b0, DEPTH-1);
      end
      for (int unsigned i = 0; i < DEPTH; i++) rd_step(AW'(i), AW'(DEPTH-1-i));

      // Bypass then array read.
      step(1'b0, 5, 0, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 0);
      rd_step(5, 5);
      // Same-address collision: port 1 wins.
      step(1'b0, 0, 7, 1'b1, 7, 32'h11, 1'b1, 7, 32'h22);
      rd_step(7, 7);
      // Entry 0 hardwired to zero.
      step(1'b0, 0, 0, 1'b1, 0, 32'h1234, 1'b1, 0, 32'hFFFF_FFFF);
      rd_step(0, 0);

      // Reset mid-clear restarts the full sequence.
      step(1'b0, 31, 31, 1'b1, 31, 32'hA5, 1'b0, 0, 0);
      rd_step(31, 31);
      step(1'b1, 31, 31, 1'b1, 30, 32'h77, 1'b1, 29, 32'h66);
      for (int i = 0; i < 10; i++) rnd_step(1'b0, DEPTH-1);
      rnd_step(1'b1, DEPTH-1);
      for (int i = 0; i < DEPTH + 1; i++) rd_step(31, 3);
      rd_step(30, 29);

      // Randomised traffic: narrow address range forces collisions and bypass hits.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) rnd_step(1'b1, DEPTH-1);
         else if ($urandom_range(0, 3) == 0) begin
            step(1'b0, AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                 1'($urandom), AW'($urandom_range(0, 3)), $urandom,
                 1'($urandom), AW'($urandom_range(0, 3)), $urandom);
         end else rnd_step(1'b0, DEPTH-1);
      end
      for (int i = 0; i < DEPTH + 2; i++) rnd_step(1'b0, DEPTH-1);
      for (int unsigned i = 0; i < DEPTH; i++) rd_step(AW'(i), AW'(i ^ 1));

      for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
      #1;
      if (sbq.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain pending=%0d required=0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
